// File: rtl/debouncer_mc.sv
// debouncer_mc: multi-channel push-button / switch debouncer.
// Each raw input passes through a two-flop synchroniser and then its own
// counter-based filter. MODE=0 passes the first edge at once and then locks
// the channel out for i_wait clocks. MODE=1 commits a new level only after it
// has been stable for the whole interval. Rise/fall strobes are registered
// together with the debounced level.
// Optional feature macro: DEBOUNCER_MC_STICKY_EN adds sticky per-channel
// event flags (write-one-to-clear through i_clear) and an interrupt line.
module debouncer_mc #(
    parameter int NIN    = 8,
    parameter int LGWAIT = 17,
    parameter int MODE   = 0
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [NIN-1:0]    i_in,
    input  logic [LGWAIT-1:0] i_wait,
    input  logic [NIN-1:0]    i_clear,
    output logic [NIN-1:0]    o_debounced,
    output logic [NIN-1:0]    o_rise,
    output logic [NIN-1:0]    o_fall,
    output logic [NIN-1:0]    o_events,
    output logic              o_int
);

    logic [NIN-1:0]             q_in;
    logic [NIN-1:0]             s_in;
    logic [NIN-1:0]             busy;
    logic [NIN-1:0]             busy_nx;
    logic [NIN-1:0][LGWAIT-1:0] cnt;
    logic [NIN-1:0][LGWAIT-1:0] cnt_nx;
    logic [NIN-1:0]             out;
    logic [NIN-1:0]             out_nx;
    logic [NIN-1:0]             rise;
    logic [NIN-1:0]             fall;

    // Two-flop synchroniser for the asynchronous board pins.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            q_in <= '0;
            s_in <= '0;
        end else begin
            q_in <= i_in;
            s_in <= q_in;
        end
    end

    // Channel state register: IDLE/BUSY flag, counter, level and edge strobes.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            busy <= '0;
            cnt  <= '0;
            out  <= '0;
            rise <= '0;
            fall <= '0;
        end else begin
            busy <= busy_nx;
            cnt  <= cnt_nx;
            out  <= out_nx;
            rise <= out_nx & ~out;
            fall <= ~out_nx & out;
        end
    end

    // Per-channel next-state logic; channels never interact.
    always_comb begin
        busy_nx = busy;
        cnt_nx  = cnt;
        out_nx  = out;
        for (int i = 0; i < NIN; i++) begin
            if (MODE == 0) begin
                if (!busy[i]) begin
                    if (s_in[i] != out[i]) begin
                        out_nx[i]  = s_in[i];
                        cnt_nx[i]  = i_wait;
                        busy_nx[i] = (i_wait != '0);
                    end
                end else begin
                    // Lockout: the input is ignored until the count expires.
                    if (cnt[i] != '0)
                        cnt_nx[i] = cnt[i] - LGWAIT'(1);
                    busy_nx[i] = (cnt[i] > LGWAIT'(1));
                end
            end else begin
                if (!busy[i]) begin
                    if (s_in[i] != out[i]) begin
                        cnt_nx[i]  = i_wait;
                        busy_nx[i] = 1'b1;
                    end
                end else if (s_in[i] == out[i]) begin
                    // Input fell back before the interval elapsed: a glitch.
                    busy_nx[i] = 1'b0;
                    cnt_nx[i]  = '0;
                end else if (cnt[i] == '0) begin
                    out_nx[i]  = s_in[i];
                    busy_nx[i] = 1'b0;
                end else begin
                    cnt_nx[i] = cnt[i] - LGWAIT'(1);
                end
            end
        end
    end

`ifdef DEBOUNCER_MC_STICKY_EN
    logic [NIN-1:0] events;

    // Sticky edge flags; a new strobe wins over a simultaneous clear.
    always_ff @(posedge i_clk) begin
        if (i_reset)
            events <= '0;
        else
            events <= (events & ~i_clear) | rise | fall;
    end
`else
    logic unused_clear;
    assign unused_clear = ^i_clear;
`endif

    // Output drive: registered level and strobes, event flags and interrupt.
    always_comb begin
        o_debounced = out;
        o_rise      = rise;
        o_fall      = fall;
`ifdef DEBOUNCER_MC_STICKY_EN
        o_events    = events;
        o_int       = |events;
`else
        o_events    = '0;
        o_int       = 1'b0;
`endif
    end

endmodule

// File: tb/tb_debouncer_mc.sv
// Bench for debouncer_mc: one eager (MODE=0) and one conservative (MODE=1)
// instance share the same stimulus. A time-based reference model (lockout
// deadline per channel for eager, run length of disagreeing samples for
// conservative) is compared against both instances every cycle, and directed
// scenarios pin hand-computed edge numbers.
module tb_debouncer_mc;
    localparam int NIN = 8;
    localparam int LGWAIT = 17;
`ifdef DEBOUNCER_MC_STICKY_EN
    localparam logic [7:0] EV_EXP  = 8'h04;
    localparam logic       INT_EXP = 1'b1;
`else
    localparam logic [7:0] EV_EXP  = 8'h00;
    localparam logic       INT_EXP = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic [NIN-1:0]    in_v;
    logic [LGWAIT-1:0] wait_v;
    logic [NIN-1:0]    clr;
    logic [NIN-1:0]    deb0, rise0, fall0, ev0;
    logic [NIN-1:0]    deb1, rise1, fall1, ev1;
    logic              int0, int1;

    debouncer_mc #(.NIN(NIN), .LGWAIT(LGWAIT), .MODE(0)) u_eager (
        .i_clk(clk), .i_reset(rst), .i_in(in_v), .i_wait(wait_v), .i_clear(clr),
        .o_debounced(deb0), .o_rise(rise0), .o_fall(fall0), .o_events(ev0), .o_int(int0)
    );

    debouncer_mc #(.NIN(NIN), .LGWAIT(LGWAIT), .MODE(1)) u_cons (
        .i_clk(clk), .i_reset(rst), .i_in(in_v), .i_wait(wait_v), .i_clear(clr),
        .o_debounced(deb1), .o_rise(rise1), .o_fall(fall1), .o_events(ev1), .o_int(int1)
    );

    int checks = 0;
    int errors = 0;
    logic chk_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    logic [NIN-1:0] m_q, m_s;
    logic [NIN-1:0] m_out0, m_rise0, m_fall0, m_ev0;
    logic [NIN-1:0] m_out1, m_rise1, m_fall1, m_ev1;
    logic [NIN-1:0] n_out0, n_out1;
    longint m_t = 0;
    longint lock_until [NIN];
    longint n_lock     [NIN];
    int     run        [NIN];
    int     n_run      [NIN];
    int     runw       [NIN];
    int     n_runw     [NIN];

    always_comb begin
        n_out0 = m_out0;
        n_out1 = m_out1;
        for (int i = 0; i < NIN; i++) begin
            n_lock[i] = lock_until[i];
            n_run[i]  = run[i];
            n_runw[i] = runw[i];
        end
        for (int i = 0; i < NIN; i++) begin
            // eager: follow any disagreement once the lockout deadline is reached
            if (m_s[i] != m_out0[i] && m_t >= lock_until[i]) begin
                n_out0[i] = m_s[i];
                n_lock[i] = m_t + longint'(wait_v) + 1;
            end
            // conservative: commit after wait+2 consecutive disagreeing samples
            if (m_s[i] == m_out1[i]) begin
                n_run[i] = 0;
            end else begin
                if (run[i] == 0) n_runw[i] = int'(wait_v);
                n_run[i] = run[i] + 1;
                if (n_run[i] == n_runw[i] + 2) begin
                    n_out1[i] = m_s[i];
                    n_run[i]  = 0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        m_t <= m_t + 1;
        if (rst) begin
            m_q <= '0; m_s <= '0;
            m_out0 <= '0; m_rise0 <= '0; m_fall0 <= '0; m_ev0 <= '0;
            m_out1 <= '0; m_rise1 <= '0; m_fall1 <= '0; m_ev1 <= '0;
            lock_until <= '{default: 0};
            run        <= '{default: 0};
            runw       <= '{default: 0};
        end else begin
            m_q     <= in_v;
            m_s     <= m_q;
            m_out0  <= n_out0;
            m_rise0 <= n_out0 & ~m_out0;
            m_fall0 <= ~n_out0 & m_out0;
            m_out1  <= n_out1;
            m_rise1 <= n_out1 & ~m_out1;
            m_fall1 <= ~n_out1 & m_out1;
            lock_until <= n_lock;
            run        <= n_run;
            runw       <= n_runw;
`ifdef DEBOUNCER_MC_STICKY_EN
            m_ev0 <= (m_ev0 & ~clr) | m_rise0 | m_fall0;
            m_ev1 <= (m_ev1 & ~clr) | m_rise1 | m_fall1;
`else
            m_ev0 <= '0;
            m_ev1 <= '0;
`endif
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("model_eager", {deb0, rise0, fall0, ev0, int0},
                    {m_out0, m_rise0, m_fall0, m_ev0, |m_ev0});
                chk("model_cons", {deb1, rise1, fall1, ev1, int1},
                    {m_out1, m_rise1, m_fall1, m_ev1, |m_ev1});
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic do_reset(input logic [LGWAIT-1:0] w);
        rst = 1'b1; in_v = '0; clr = '0; wait_v = w;
        step(2);
        rst = 1'b0;
        step(4);
    endtask

    int r_edge, f_edge, r_cnt, f_cnt, r7_edge, both, seen;
    logic [NIN-1:0] snap;

    // ---------------- directed scenarios ----------------
    initial begin
        // Reset release with ch0 held high
        rst = 1'b1; in_v = 8'h01; wait_v = 17'd10; clr = '0;
        step(1);
        chk_en = 1'b1;
        step(2);
        chk("reset_eager", {deb0, rise0, fall0, ev0, int0}, 0);
        chk("reset_cons",  {deb1, rise1, fall1, ev1, int1}, 0);
        rst = 1'b0;
        step(2);
        chk("rel_e2_deb", deb0, 8'h00);
        step(1);
        chk("rel_e3_deb",  deb0,  8'h01);
        chk("rel_e3_rise", rise0, 8'h01);
        chk("rel_e3_fall", fall0, 8'h00);
        step(1);
        chk("rel_e4_rise", rise0, 8'h00);
        step(9);
        chk("rel_cons_e13_deb", deb1, 8'h00);
        step(1);
        chk("rel_cons_e14_deb",  deb1,  8'h01);
        chk("rel_cons_e14_rise", rise1, 8'h01);

        // Eager lockout with bouncing on ch0
        do_reset(17'd100);
        r_edge = -1; f_edge = -1; r_cnt = 0; f_cnt = 0;
        in_v[0] = 1'b1;
        for (int k = 0; k <= 115; k++) begin
            step(1);
            if (rise0[0]) begin r_cnt++; if (r_edge < 0) r_edge = k; end
            if (fall0[0]) begin f_cnt++; if (f_edge < 0) f_edge = k; end
            if (k <= 50) in_v[0] = (((k / 10) % 2) == 0) ? k[0] : 1'b1;
            else if (k >= 60) in_v[0] = 1'b0;
        end
        chk("lock_rise_edge",  r_edge, 2);
        chk("lock_rise_count", r_cnt,  1);
        chk("lock_fall_edge",  f_edge, 103);
        chk("lock_fall_count", f_cnt,  1);

        // Conservative glitch rejection on ch3
        do_reset(17'd20);
        seen = 0; r_cnt = 0;
        in_v[3] = 1'b1;
        for (int k = 0; k <= 40; k++) begin
            step(1);
            if (deb1[3]) seen++;
            if (rise1[3] || fall1[3]) r_cnt++;
            if (k == 14) in_v[3] = 1'b0;
        end
        chk("glitch_level",   seen,  0);
        chk("glitch_strobes", r_cnt, 0);
        r_edge = -1;
        in_v[3] = 1'b1;
        for (int k = 0; k <= 30; k++) begin
            step(1);
            if (rise1[3] && r_edge < 0) r_edge = k;
        end
        chk("glitch_then_rise", r_edge, 23);

        // Channel independence, ch0 and ch7 five cycles apart
        do_reset(17'd8);
        r_edge = -1; r7_edge = -1; both = 0; snap = '0;
        in_v[0] = 1'b1;
        for (int k = 0; k <= 25; k++) begin
            step(1);
            if (rise1[0] && r_edge < 0)  r_edge = k;
            if (rise1[7] && r7_edge < 0) r7_edge = k;
            if (rise1[0] && rise1[7]) both++;
            if (k == 11) snap = deb1;
            if (k == 4) in_v[7] = 1'b1;
        end
        chk("indep_ch0_edge", r_edge,  11);
        chk("indep_ch7_edge", r7_edge, 16);
        chk("indep_combined", both,    0);
        chk("indep_snap_k11", snap,    8'h01);

        // Sticky events on ch2 (eager instance)
        do_reset(17'd4);
        in_v[2] = 1'b1;
        for (int k = 0; k <= 20; k++) begin
            step(1);
            if (k == 2) chk("sticky_rise", rise0, 8'h04);
            if (k == 3) begin
                chk("sticky_set_ev",  ev0,  EV_EXP);
                chk("sticky_set_int", int0, INT_EXP);
            end
            if (k == 9) in_v[2] = 1'b0;
            if (k == 12) begin
                chk("sticky_fall", fall0, 8'h04);
                clr = 8'h04;
            end
            if (k == 13) begin
                chk("sticky_set_beats_clr", ev0, EV_EXP);
                clr = 8'h00;
            end
            if (k == 15) clr = 8'h04;
            if (k == 16) begin
                chk("sticky_clr_ev",  ev0,  8'h00);
                chk("sticky_clr_int", int0, 1'b0);
                clr = 8'h00;
            end
        end

        // Reset in the middle of a long conservative count
        do_reset(17'd1000);
        in_v[1] = 1'b1;
        for (int k = 0; k <= 502; k++) begin
            step(1);
            if (k == 400) chk("midcount_deb", deb1, 8'h00);
            if (k == 502) rst = 1'b1;
        end
        step(1);
        chk("midrst_cons", {deb1, rise1, fall1, ev1, int1}, 0);
        chk("midrst_eager", {deb0, rise0, fall0, ev0, int0}, 0);
        rst = 1'b0;
        r_edge = -1;
        for (int j = 0; j <= 1010; j++) begin
            step(1);
            if (rise1[1] && r_edge < 0) r_edge = j;
        end
        chk("midrst_commit_edge", r_edge, 1003);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
